// File: rtl/matmult_spi_pkg.sv
// Shared SPI constants and the host controller state encoding for the matmult SPI link.
package matmult_spi_pkg;

   localparam int unsigned SPI_TX_BITS         = 8;
   localparam int unsigned SPI_RX_BITS         = 18;
   localparam int unsigned SPI_CLK_DIV_DEFAULT = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_LINK,
      S_HOLD,
      S_GAP
   } spi_host_state_t;

endpackage

// File: rtl/spi_host_if.sv
// Host-side command (valid/ready) and response (valid-only) bundle for spi_host.
interface spi_host_if
   import matmult_spi_pkg::*;
#(
   parameter int unsigned TX_BITS = SPI_TX_BITS,
   parameter int unsigned RX_BITS = SPI_RX_BITS
) ();

   logic               cmd_valid;
   logic               cmd_ready;
   logic               cmd_write;
   logic               cmd_last;
   logic [TX_BITS-1:0] cmd_data;
   logic               rsp_valid;
   logic [RX_BITS-1:0] rsp_data;

   modport master (
      output cmd_valid, cmd_write, cmd_last, cmd_data,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_last, cmd_data,
      output cmd_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/spi_host_clk_gen.sv
// SPI clock generator: CLK_DIV sys_clk cycles per phase, edge strobes aligned with spi_clk toggles.
module spi_clk_gen #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic spi_clk,
   output logic rise_stb,
   output logic fall_stb
);

   localparam int unsigned   CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sclk_q, sclk_d;
   logic          wrap;

   always_comb begin
      wrap   = en && (cnt_q == LAST);
      cnt_d  = '0;
      sclk_d = 1'b0;
      if (en) begin
         cnt_d  = wrap ? '0 : cnt_q + 1'b1;
         sclk_d = wrap ? ~sclk_q : sclk_q;
      end
      rise_stb = wrap && !sclk_q;
      fall_stb = wrap && sclk_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

   assign spi_clk = sclk_q;

endmodule

// File: rtl/spi_host.sv
// Mode-0 MSB-first SPI controller: 8-bit write frames, 18-bit read frames, cs held across linked frames.
module spi_host
   import matmult_spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = SPI_CLK_DIV_DEFAULT,
   parameter int unsigned TX_BITS = SPI_TX_BITS,
   parameter int unsigned RX_BITS = SPI_RX_BITS
) (
   input  logic       sys_clk,
   input  logic       rst,
   spi_host_if.slave  bus,
   output logic       busy,
   output logic       spi_clk,
   output logic       cs,
   output logic       mosi,
   input  logic       miso
);

   localparam int unsigned   SR_W     = (TX_BITS > RX_BITS) ? TX_BITS : RX_BITS;
   localparam int unsigned   CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned   BW       = $clog2(SR_W + 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
   localparam logic [BW-1:0] TX_LEN   = BW'(TX_BITS);
   localparam logic [BW-1:0] RX_LEN   = BW'(RX_BITS);

   spi_host_state_t    state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [BW-1:0]      bits_q, bits_d;
   logic               wr_q, wr_d;
   logic               last_q, last_d;
   logic [SR_W-1:0]    tx_q, tx_d;
   logic [RX_BITS-1:0] rx_q, rx_d;
   logic [RX_BITS-1:0] rsp_q, rsp_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic               cs_q, cs_d;
   logic               mosi_q, mosi_d;
   logic               accept, shift_en, rise, fall;

   assign shift_en = (state_q == S_SHIFT);

   spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk      (sys_clk),
      .rst_n    (rst),
      .en       (shift_en),
      .spi_clk  (spi_clk),
      .rise_stb (rise),
      .fall_stb (fall)
   );

   always_comb begin
      accept      = bus.cmd_valid && ready_q;
      state_d     = state_q;
      cnt_d       = '0;
      bits_d      = bits_q;
      wr_d        = wr_q;
      last_d      = last_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      rsp_d       = rsp_q;
      rsp_valid_d = 1'b0;

      // IDLE and LINK share the command load; only the successor state differs
      if (accept && (state_q == S_IDLE || state_q == S_LINK)) begin
         wr_d    = bus.cmd_write;
         last_d  = bus.cmd_last;
         tx_d    = bus.cmd_write ? (SR_W'(bus.cmd_data) << (SR_W - TX_BITS)) : '0;
         bits_d  = bus.cmd_write ? TX_LEN : RX_LEN;
         state_d = (state_q == S_IDLE) ? S_SETUP : S_SHIFT;
      end

      case (state_q)
         S_SETUP: if (cnt_q == DIV_LAST) state_d = S_SHIFT; else cnt_d = cnt_q + 1'b1;
         S_HOLD:  if (cnt_q == DIV_LAST) state_d = S_GAP;   else cnt_d = cnt_q + 1'b1;
         S_GAP:   if (cnt_q == DIV_LAST) state_d = S_IDLE;  else cnt_d = cnt_q + 1'b1;
         S_SHIFT: begin
            if (rise) rx_d = {rx_q[RX_BITS-2:0], miso};
            if (fall) begin
               tx_d   = tx_q << 1;
               bits_d = bits_q - 1'b1;
               if (bits_q == BW'(1)) begin
                  state_d = last_q ? S_HOLD : S_LINK;
                  if (!wr_q) begin
                     rsp_valid_d = 1'b1;
                     rsp_d       = rx_q;
                  end
               end
            end
         end
         default: ;
      endcase

      ready_d = (state_d == S_IDLE) || (state_d == S_LINK);
      busy_d  = (state_d != S_IDLE);
      cs_d    = (state_d == S_IDLE) || (state_d == S_GAP);
      mosi_d  = wr_d && (state_d == S_SETUP || state_d == S_SHIFT) && tx_d[SR_W-1];
   end

   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bits_q      <= '0;
         wr_q        <= 1'b0;
         last_q      <= 1'b0;
         tx_q        <= '0;
         rx_q        <= '0;
         rsp_q       <= '0;
         rsp_valid_q <= 1'b0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         cs_q        <= 1'b1;
         mosi_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bits_q      <= bits_d;
         wr_q        <= wr_d;
         last_q      <= last_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         rsp_q       <= rsp_d;
         rsp_valid_q <= rsp_valid_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         cs_q        <= cs_d;
         mosi_q      <= mosi_d;
      end
   end

   assign bus.cmd_ready = ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_q;
   assign busy          = busy_q;
   assign cs            = cs_q;
   assign mosi          = mosi_q;

endmodule

// File: doc/spi_host.md
Name: spi_host

Overview:
- SPI controller (mode 0, MSB first) for driving the matmult accelerator's SPI target port from a host-side block on the same die or FPGA.
- Generates spi_clk and cs, and shifts out 8-bit write frames on mosi.
- Captures 18-bit read frames from miso.
- A valid/ready command interface and a valid-only response interface face the host logic.

Parameters:
- CLK_DIV, 4: spi_clk half-period in sys_clk cycles; legal range 2..255.
- TX_BITS, 8: write frame length (matches the target's rx_data width).
- RX_BITS, 18: read frame length (matches the target's tx_data width).

Ports:
- sys_clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  input  1  1 = write frame (TX_BITS), 0 = read frame (RX_BITS).
- cmd_last  input  1  release cs after this frame.
- cmd_data  input  TX_BITS  write payload; ignored for reads.
- rsp_valid  output  1  one-cycle pulse, read data available.
- rsp_data  output  RX_BITS  captured read word.
- busy  output  1  high in every state except IDLE.
- spi_clk  output  1  SPI clock, idles low.
- cs  output  1  chip select, active-low.
- mosi  output  1  controller data out.
- miso  input  1  target data in.

Behaviour:
- Reset (rst=0, asynchronous, immediate) forces:
  - cs=1, spi_clk=0, mosi=0;
  - cmd_ready=0, rsp_valid=0, rsp_data=0, busy=0;
  - state=IDLE, all counters=0.
- Reset mid-frame aborts the frame. No rsp_valid is produced and partial data is discarded. cmd_ready=1 on the first sys_clk edge after release.
- States: IDLE, SETUP, SHIFT, LINK, HOLD, GAP.
- IDLE:
  - cs=1, cmd_ready=1.
  - On accept: latch cmd_write, cmd_last and cmd_data; load bit counter with TX_BITS or RX_BITS.
  - Next cycle cs=0 and state goes to SETUP.
- SETUP: cs low, spi_clk low for CLK_DIV cycles, then SHIFT.
- SHIFT: half-period counter runs CLK_DIV cycles per phase.
  - mosi shows the current MSB of the shift register during the low phase. mosi=0 for the whole of a read frame.
  - End of low phase: spi_clk rises and miso is shifted into the rx register on the same sys_clk edge.
  - End of high phase: spi_clk falls, the tx register shifts left and the bit counter decrements.
  - After the final falling edge: cmd_last=1 goes to HOLD, otherwise to LINK.
  - A SHIFT phase lasts exactly 2*CLK_DIV*N cycles (N = frame bits).
- Read completion: rsp_valid=1 for exactly one cycle, on the cycle after the final falling edge. rsp_data holds the captured word and stays stable until the next read completes.
- LINK:
  - cs stays low, spi_clk low, cmd_ready=1.
  - On accept, go directly to SHIFT with no SETUP.
  - LINK is held indefinitely with no command pending; cs remains asserted.
- HOLD: cs low, spi_clk low for CLK_DIV cycles, then cs=1 and GAP.
- GAP: cs high for CLK_DIV cycles with cmd_ready=0, then IDLE.
- cmd_ready=0 in SETUP, SHIFT, HOLD and GAP. cmd_valid during these states is not consumed and must be held by the host.
- Single write frame with cmd_last: cs low for (2*TX_BITS+2)*CLK_DIV = 72 cycles at defaults. Accept-to-accept is 77 cycles.
- miso is sampled directly with no synchronizer. The target launches miso on the falling edge, at least CLK_DIV-1 cycles before sampling, so CLK_DIV>=2 is required.
- Counter widths derive from $clog2 of CLK_DIV and RX_BITS. Frame length selection muxes TX_BITS/RX_BITS; the shift register is max(TX_BITS,RX_BITS) wide, left-aligned.

Decomposition:
- Package matmult_spi_pkg:
  - spi_host_state_t enum (six states);
  - SPI_TX_BITS=8, SPI_RX_BITS=18 constants, shared with the target and the fsm;
  - SPI_CLK_DIV_DEFAULT.
- Sub-module spi_clk_gen: half-period counter producing rise_stb/fall_stb and spi_clk; enable driven by the SHIFT state.
- Main FSM, shift registers and handshake live in spi_host.

Test Plan:
- Write 0xA5, cmd_last=1, CLK_DIV=4:
  - cs falls 1 cycle after accept;
  - 8 rising edges with mosi = 1,0,1,0,0,1,0,1 at each;
  - cs high after 72 cycles; cmd_ready returns 4 cycles later.
- Read frame, target model shifting 18'h2A5C3:
  - exactly 18 rising edges, mosi=0 throughout;
  - one-cycle rsp_valid with rsp_data=18'h2A5C3.
- Back-to-back writes 0x01 (last=0) then 0x02 (last=1): cs stays low across both, 16 rising edges total, no SETUP between frames.
- Assert rst low after 3 bits of a read:
  - cs=1 and spi_clk=0 without waiting for a sys_clk edge;
  - no rsp_valid;
  - cmd_ready=1 one cycle after release.
- cmd_valid held high during SHIFT: cmd_ready=0; command accepted only in LINK/IDLE; the second frame's data is intact.
- End-to-end against the matmult top:
  - 8 write bytes load [[1,2],[3,4]] and [[5,6],[7,8]];
  - 4 reads return 19, 22, 43, 50.
